clangpu_lexer: RTL and testbench
================================

Name: clangpu_lexer

Overview:
Tokenizer stage of ClangPU, directly downstream of the fetch character FIFO (ffifo_o_valid / ffifo_o_data). It consumes source bytes one per cycle and groups them into C-subset tokens: decimal numbers, identifiers and keywords, single- and two-char punctuators, error, and end-of-file. Completed tokens sit in a one-entry output register with a valid/ready handshake toward the parser stage.

Parameters:
ID_CHARS, 4, number of leading identifier chars packed into O_VALUE (1..4)
LINE_W, 16, width of the line counter and O_LINE

Ports:
CCLK  input  1  core clock; all state on rising edge
CRST  input  1  synchronous reset, active-high
I_VALID  input  1  input char valid (from ffifo_o_valid)
I_CHAR  input  8  input char (from ffifo_o_data)
I_READY  output  1  char accepted this cycle when I_VALID && I_READY
O_VALID  output  1  token valid
O_TYPE  output  3  1=NUM 2=IDENT 3=PUNCT 4=EOF 5=ERR
O_VALUE  output  32  token payload
O_LEN  output  6  IDENT length, saturating at 63; 0 for other types
O_LINE  output  LINE_W  line number of the token's first char
O_READY  input  1  consumer accepts the token when O_VALID && O_READY

Behaviour:
- Reset (CRST=1 at a clock edge): state=SKIP; O_VALID=0, O_TYPE=0, O_VALUE=0, O_LEN=0, O_LINE=0; line counter=1. Reset mid-token drops the token and any pending output.
- States: SKIP, NUM, IDENT, OP1, EMIT, DONE.
- I_READY is combinational from state and I_CHAR. A token terminator is never consumed. It stays on I_CHAR and is re-examined in SKIP after the emit.
- SKIP:
  - Space, \t, \r are consumed and ignored.
  - \n is consumed and increments the line counter. The counter saturates at all-ones.
  - Digit: consume, acc=digit, go to NUM.
  - [A-Za-z_]: consume, start IDENT.
  - One of < > = !: consume, go to OP1.
  - One of + - * / ; ( ) { } , & | %: consume, build PUNCT value=char, go to EMIT.
  - 0x00: go to EMIT with EOF (not consumed).
  - Any other char: consume, build ERR value=char, go to EMIT.
  - The line of the token start is latched when the first char is consumed.
- NUM:
  - Digit: consume, acc = acc*10 + digit, truncated mod 2^32 (wrap, no error).
  - Non-digit: not consumed, emit NUM value=acc.
- IDENT:
  - [A-Za-z0-9_]: consume, len++ (saturate 63). The char is packed into O_VALUE byte index len while len<ID_CHARS, first char in bits [7:0]. Unused bytes are 0.
  - Other char: not consumed, emit IDENT.
- OP1:
  - '=' : consume, value = {16'h0, "=", first}, i.e. bits[15:8]=0x3D.
  - Anything else: not consumed, value = first char only.
  - Either way, go to EMIT as PUNCT.
- EMIT: load the output register when !O_VALID || O_READY. This permits back-to-back tokens on consecutive cycles. Then go to SKIP; an EOF token goes to DONE instead. I_READY=0 in EMIT.
- DONE: I_READY=0 permanently until reset. O_VALID clears after the EOF token handshake.
- Output register: it holds all O_* fields stable while O_VALID && !O_READY. O_VALID falls the cycle after the handshake unless a new token is loaded in the same cycle.
- Latency:
  - Single-char PUNCT: 2 cycles from acceptance to O_VALID.
  - NUM/IDENT: O_VALID 2 cycles after the terminator is first presented.
- I_VALID=0 in any state: hold state; no timeout.

Optional Feature:
Macro CLANGPU_LEX_HEX_EN.
- Defined: "0x"/"0X" followed by hex digits lexes as NUM, acc = acc*16 + nibble (wrap mod 2^32). "0x" with no hex digit emits NUM 0, and 'x' is then lexed as IDENT.
- Undefined: "0x1F" lexes as NUM 0, then IDENT "x1F".
- No other behaviour differs.

Test Plan:
- Feed "int a;\0" at full rate with O_READY=1 → tokens, all line 1:
  - IDENT O_VALUE=0x00746E69, len 3
  - IDENT 0x61, len 1
  - PUNCT 0x3B
  - EOF
  After EOF: I_READY stays 0.
- Feed "a<=4294967297 !x\n\0" → tokens:
  - IDENT 0x61
  - PUNCT 0x3D3C
  - NUM 1 (wrap)
  - PUNCT 0x21
  - IDENT 0x78
  - EOF with O_LINE=2
- Input "12 + 3\0" with O_READY held 0 for 10 cycles after the first O_VALID → NUM 12 stays stable, I_READY=0 once the next token completes, and no token is lost. Sequence on release: NUM 12, PUNCT 0x2B, NUM 3, EOF.
- Input "ab@\0" → IDENT 0x6261 len 2, ERR 0x40, EOF. Random I_VALID gaps must give the identical token stream.
- Assert CRST mid-identifier "abcd" → next cycle O_VALID=0 and state=SKIP. Following "9\0" → NUM 9 line 1, EOF.
- With CLANGPU_LEX_HEX_EN: "0x1F\0" → NUM 31, EOF. Without it: NUM 0, IDENT 0x00463178 len 3, EOF.

Source files
------------

// File: rtl/clangpu_lexer.sv
// clangpu_lexer: tokenizer between the fetch char FIFO and the parser.
// Ports: CCLK/CRST clock and sync reset; I_VALID/I_CHAR/I_READY char in;
//   O_VALID/O_TYPE/O_VALUE/O_LEN/O_LINE/O_READY registered token out.
// Optional: define CLANGPU_LEX_HEX_EN for 0x/0X hex number literals.
module clangpu_lexer #(
  parameter int ID_CHARS = 4,
  parameter int LINE_W   = 16
) (
  input  logic              CCLK,
  input  logic              CRST,
  input  logic              I_VALID,
  input  logic [7:0]        I_CHAR,
  output logic              I_READY,
  output logic              O_VALID,
  output logic [2:0]        O_TYPE,
  output logic [31:0]       O_VALUE,
  output logic [5:0]        O_LEN,
  output logic [LINE_W-1:0] O_LINE,
  input  logic              O_READY
);

  typedef enum logic [2:0] {
    S_SKIP, S_NUM, S_IDENT, S_OP1, S_EMIT, S_DONE
  } state_t;

  localparam logic [2:0] T_NUM   = 3'd1;
  localparam logic [2:0] T_IDENT = 3'd2;
  localparam logic [2:0] T_PUNCT = 3'd3;
  localparam logic [2:0] T_EOF   = 3'd4;
  localparam logic [2:0] T_ERR   = 3'd5;

  state_t state, state_nx;

  logic [31:0]       acc, acc_nx;
  logic [2:0]        tok_type, tok_type_nx;
  logic [5:0]        tok_len, tok_len_nx;
  logic [LINE_W-1:0] tok_line, tok_line_nx;
  logic [LINE_W-1:0] line_cnt, line_cnt_nx;
  logic              load;
  logic              take;

  logic c_digit, c_alpha, c_ident, c_ws, c_nl;
  logic c_op1, c_punct, c_nul, c_eq;
  logic num_take;

  assign c_digit = (I_CHAR >= 8'h30) && (I_CHAR <= 8'h39);
  assign c_alpha = ((I_CHAR >= 8'h41) && (I_CHAR <= 8'h5A))
                || ((I_CHAR >= 8'h61) && (I_CHAR <= 8'h7A))
                || (I_CHAR == 8'h5F);
  assign c_ident = c_alpha || c_digit;
  assign c_ws    = (I_CHAR == 8'h20) || (I_CHAR == 8'h09)
                || (I_CHAR == 8'h0D);
  assign c_nl    = (I_CHAR == 8'h0A);
  assign c_eq    = (I_CHAR == 8'h3D);
  assign c_op1   = (I_CHAR == 8'h3C) || (I_CHAR == 8'h3E)
                || c_eq || (I_CHAR == 8'h21);
  assign c_punct = (I_CHAR == 8'h2B) || (I_CHAR == 8'h2D)
                || (I_CHAR == 8'h2A) || (I_CHAR == 8'h2F)
                || (I_CHAR == 8'h3B) || (I_CHAR == 8'h28)
                || (I_CHAR == 8'h29) || (I_CHAR == 8'h7B)
                || (I_CHAR == 8'h7D) || (I_CHAR == 8'h2C)
                || (I_CHAR == 8'h26) || (I_CHAR == 8'h7C)
                || (I_CHAR == 8'h25);
  assign c_nul   = (I_CHAR == 8'h00);

`ifdef CLANGPU_LEX_HEX_EN
  // first_zero: number so far is a lone '0', so an x/X may follow.
  // hex_pend: "0x" consumed but no hex digit yet; if the number ends
  // here the consumed 'x' is replayed as the start of an identifier.
  logic       first_zero, first_zero_nx;
  logic       hex_mode, hex_mode_nx;
  logic       hex_pend, hex_pend_nx;
  logic [7:0] x_char, x_char_nx;
  logic       c_hex, c_x;
  logic [3:0] nibble;

  assign c_x   = (I_CHAR == 8'h78) || (I_CHAR == 8'h58);
  assign c_hex = c_digit
              || ((I_CHAR >= 8'h41) && (I_CHAR <= 8'h46))
              || ((I_CHAR >= 8'h61) && (I_CHAR <= 8'h66));
  assign nibble = c_digit ? I_CHAR[3:0] : I_CHAR[3:0] + 4'd9;
  assign num_take = hex_mode ? c_hex : (c_digit || (first_zero && c_x));
`else
  assign num_take = c_digit;
`endif

  assign take = I_VALID && I_READY;

  always_ff @(posedge CCLK) begin
    if (CRST) begin
      state    <= S_SKIP;
      acc      <= '0;
      tok_type <= '0;
      tok_len  <= '0;
      tok_line <= '0;
      line_cnt <= LINE_W'(1);
      O_VALID  <= 1'b0;
      O_TYPE   <= '0;
      O_VALUE  <= '0;
      O_LEN    <= '0;
      O_LINE   <= '0;
`ifdef CLANGPU_LEX_HEX_EN
      first_zero <= 1'b0;
      hex_mode   <= 1'b0;
      hex_pend   <= 1'b0;
      x_char     <= '0;
`endif
    end else begin
      state    <= state_nx;
      acc      <= acc_nx;
      tok_type <= tok_type_nx;
      tok_len  <= tok_len_nx;
      tok_line <= tok_line_nx;
      line_cnt <= line_cnt_nx;
`ifdef CLANGPU_LEX_HEX_EN
      first_zero <= first_zero_nx;
      hex_mode   <= hex_mode_nx;
      hex_pend   <= hex_pend_nx;
      x_char     <= x_char_nx;
`endif
      if (load) begin
        O_VALID <= 1'b1;
        O_TYPE  <= tok_type;
        O_VALUE <= acc;
        O_LEN   <= tok_len;
        O_LINE  <= tok_line;
      end else if (O_READY) begin
        O_VALID <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    acc_nx      = acc;
    tok_type_nx = tok_type;
    tok_len_nx  = tok_len;
    tok_line_nx = tok_line;
    line_cnt_nx = line_cnt;
    load        = 1'b0;
`ifdef CLANGPU_LEX_HEX_EN
    first_zero_nx = first_zero;
    hex_mode_nx   = hex_mode;
    hex_pend_nx   = hex_pend;
    x_char_nx     = x_char;
`endif
    case (state)
      S_SKIP: begin
        if (I_VALID) begin
          tok_line_nx = line_cnt;
          tok_len_nx  = 6'd0;
          acc_nx      = {24'h0, I_CHAR};
          unique case (1'b1)
            c_ws: ;
            c_nl: begin
              if (!(&line_cnt)) line_cnt_nx = line_cnt + 1'b1;
            end
            c_digit: begin
              acc_nx      = {28'h0, I_CHAR[3:0]};
              tok_type_nx = T_NUM;
              state_nx    = S_NUM;
`ifdef CLANGPU_LEX_HEX_EN
              first_zero_nx = (I_CHAR == 8'h30);
              hex_mode_nx   = 1'b0;
              hex_pend_nx   = 1'b0;
`endif
            end
            c_alpha: begin
              tok_type_nx = T_IDENT;
              tok_len_nx  = 6'd1;
              state_nx    = S_IDENT;
            end
            c_op1: begin
              tok_type_nx = T_PUNCT;
              state_nx    = S_OP1;
            end
            c_punct: begin
              tok_type_nx = T_PUNCT;
              state_nx    = S_EMIT;
            end
            c_nul: begin
              acc_nx      = '0;
              tok_type_nx = T_EOF;
              state_nx    = S_EMIT;
            end
            default: begin
              tok_type_nx = T_ERR;
              state_nx    = S_EMIT;
            end
          endcase
        end
      end
      S_NUM: begin
        if (take) begin
`ifdef CLANGPU_LEX_HEX_EN
          first_zero_nx = 1'b0;
          if (hex_mode) begin
            acc_nx      = {acc[27:0], nibble};
            hex_pend_nx = 1'b0;
          end else if (c_digit) begin
            acc_nx = acc * 32'd10 + {28'h0, I_CHAR[3:0]};
          end else begin
            hex_mode_nx = 1'b1;
            hex_pend_nx = 1'b1;
            x_char_nx   = I_CHAR;
          end
`else
          acc_nx = acc * 32'd10 + {28'h0, I_CHAR[3:0]};
`endif
        end else if (I_VALID) begin
          state_nx = S_EMIT;
        end
      end
      S_IDENT: begin
        if (take) begin
          for (int i = 0; i < 4; i++) begin
            if (i < ID_CHARS && tok_len == 6'(i))
              acc_nx[i*8 +: 8] = I_CHAR;
          end
          if (!(&tok_len)) tok_len_nx = tok_len + 6'd1;
        end else if (I_VALID) begin
          state_nx = S_EMIT;
        end
      end
      S_OP1: begin
        if (I_VALID) begin
          if (c_eq) acc_nx[15:8] = 8'h3D;
          state_nx = S_EMIT;
        end
      end
      S_EMIT: begin
        if (!O_VALID || O_READY) begin
          load     = 1'b1;
          state_nx = (tok_type == T_EOF) ? S_DONE : S_SKIP;
`ifdef CLANGPU_LEX_HEX_EN
          if (hex_pend) begin
            acc_nx      = {24'h0, x_char};
            tok_type_nx = T_IDENT;
            tok_len_nx  = 6'd1;
            state_nx    = S_IDENT;
            hex_pend_nx = 1'b0;
            hex_mode_nx = 1'b0;
          end
`endif
        end
      end
      S_DONE: ;
      default: state_nx = S_SKIP;
    endcase
  end

  // Terminators are never consumed; they are re-examined in SKIP.
  always_comb begin
    I_READY = 1'b0;
    case (state)
      S_SKIP:  I_READY = !c_nul;
      S_NUM:   I_READY = num_take;
      S_IDENT: I_READY = c_ident;
      S_OP1:   I_READY = c_eq;
      default: I_READY = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_clangpu_lexer.sv
// tb_clangpu_lexer: token stream checks for clangpu_lexer.
// Expected tokens are queued per input string and popped on handshake.
module tb_clangpu_lexer;

  logic        CCLK = 1'b0;
  logic        CRST = 1'b1;
  logic        I_VALID = 1'b0;
  logic [7:0]  I_CHAR = 8'h00;
  logic        I_READY;
  logic        O_VALID;
  logic [2:0]  O_TYPE;
  logic [31:0] O_VALUE;
  logic [5:0]  O_LEN;
  logic [15:0] O_LINE;
  logic        O_READY = 1'b1;

  clangpu_lexer #(.ID_CHARS(4), .LINE_W(16)) dut (
    .CCLK(CCLK), .CRST(CRST),
    .I_VALID(I_VALID), .I_CHAR(I_CHAR), .I_READY(I_READY),
    .O_VALID(O_VALID), .O_TYPE(O_TYPE), .O_VALUE(O_VALUE),
    .O_LEN(O_LEN), .O_LINE(O_LINE), .O_READY(O_READY)
  );

  always #5 CCLK = ~CCLK;

  typedef struct {
    int          cs;
    logic [2:0]  typ;
    logic [31:0] val;
    logic [5:0]  len;
    logic [15:0] line;
  } tok_t;

  tok_t  tbl[$];
  tok_t  sb[$];
  string src[8];
  int    n_checks = 0;
  int    n_fail = 0;
  int    w;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CCLK) begin : mon
    tok_t e;
    if (!CRST && O_VALID && O_READY) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_token: got type %0d value %h expected none",
                 O_TYPE, O_VALUE);
      end else begin
        e = sb.pop_front();
        check("tok_type", 32'(O_TYPE), 32'(e.typ));
        check("tok_value", O_VALUE, e.val);
        check("tok_len", 32'(O_LEN), 32'(e.len));
        check("tok_line", 32'(O_LINE), 32'(e.line));
      end
    end
  end

  task automatic push(input logic [2:0] t, input logic [31:0] v,
                      input logic [5:0] l, input logic [15:0] ln);
    sb.push_back(tok_t'{0, t, v, l, ln});
  endtask

  task automatic do_reset();
    CRST = 1'b1;
    I_VALID = 1'b0;
    @(posedge CCLK); #1;
    CRST = 1'b0;
    O_READY = 1'b1;
  endtask

  // Presents s followed by a NUL until every queued token has arrived.
  task automatic feed(input string s, input bit gaps);
    int   idx = 0;
    int   cyc = 0;
    logic tk;
    while (sb.size() > 0 && cyc < 3000) begin
      if (idx <= s.len()) begin
        I_VALID = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        I_CHAR  = (idx == s.len()) ? 8'h00 : s[idx];
      end else begin
        I_VALID = 1'b0;
      end
      @(negedge CCLK);
      tk = I_VALID && I_READY;
      @(posedge CCLK); #1;
      if (tk) idx++;
      cyc++;
    end
    I_VALID = 1'b0;
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL feed_timeout: got %0d tokens missing expected 0",
               sb.size());
      sb.delete();
    end
  endtask

  task automatic drive_char(input logic [7:0] c);
    int   n = 0;
    logic tk = 1'b0;
    I_VALID = 1'b1;
    I_CHAR  = c;
    while (!tk && n < 50) begin
      @(negedge CCLK);
      tk = I_READY;
      @(posedge CCLK); #1;
      n++;
    end
    I_VALID = 1'b0;
    if (!tk) begin
      n_checks++;
      n_fail++;
      $display("FAIL drive_char: char %h not accepted expected accept", c);
    end
  endtask

  task automatic check_done();
    I_VALID = 1'b1;
    I_CHAR  = 8'h61;
    repeat (2) begin
      @(negedge CCLK);
      check("done_i_ready", 32'(I_READY), 32'd0);
      check("done_o_valid", 32'(O_VALID), 32'd0);
      @(posedge CCLK); #1;
    end
    I_VALID = 1'b0;
  endtask

  task automatic run_case(input int c, input bit gaps);
    foreach (tbl[i]) if (tbl[i].cs == c) sb.push_back(tbl[i]);
    feed(src[c], gaps);
    check_done();
  endtask

  initial begin
    src[0] = "int a;";
    src[1] = "a<=4294967297 !x\n";
    src[2] = "ab@";
    src[3] = "ab@";
    src[4] = "0x1F";
    src[5] = "0xg";
    src[6] = "a\n\nbcdefg";
    tbl.push_back(tok_t'{0, 3'd2, 32'h00746E69, 6'd3, 16'd1});
    tbl.push_back(tok_t'{0, 3'd2, 32'h61, 6'd1, 16'd1});
    tbl.push_back(tok_t'{0, 3'd3, 32'h3B, 6'd0, 16'd1});
    tbl.push_back(tok_t'{0, 3'd4, 32'h0, 6'd0, 16'd1});
    tbl.push_back(tok_t'{1, 3'd2, 32'h61, 6'd1, 16'd1});
    tbl.push_back(tok_t'{1, 3'd3, 32'h3D3C, 6'd0, 16'd1});
    tbl.push_back(tok_t'{1, 3'd1, 32'h1, 6'd0, 16'd1});
    tbl.push_back(tok_t'{1, 3'd3, 32'h21, 6'd0, 16'd1});
    tbl.push_back(tok_t'{1, 3'd2, 32'h78, 6'd1, 16'd1});
    tbl.push_back(tok_t'{1, 3'd4, 32'h0, 6'd0, 16'd2});
    for (int k = 2; k <= 3; k++) begin
      tbl.push_back(tok_t'{k, 3'd2, 32'h6261, 6'd2, 16'd1});
      tbl.push_back(tok_t'{k, 3'd5, 32'h40, 6'd0, 16'd1});
      tbl.push_back(tok_t'{k, 3'd4, 32'h0, 6'd0, 16'd1});
    end
`ifdef CLANGPU_LEX_HEX_EN
    tbl.push_back(tok_t'{4, 3'd1, 32'd31, 6'd0, 16'd1});
`else
    tbl.push_back(tok_t'{4, 3'd1, 32'd0, 6'd0, 16'd1});
    tbl.push_back(tok_t'{4, 3'd2, 32'h00463178, 6'd3, 16'd1});
`endif
    tbl.push_back(tok_t'{4, 3'd4, 32'h0, 6'd0, 16'd1});
    tbl.push_back(tok_t'{5, 3'd1, 32'd0, 6'd0, 16'd1});
    tbl.push_back(tok_t'{5, 3'd2, 32'h6778, 6'd2, 16'd1});
    tbl.push_back(tok_t'{5, 3'd4, 32'h0, 6'd0, 16'd1});
    tbl.push_back(tok_t'{6, 3'd2, 32'h61, 6'd1, 16'd1});
    tbl.push_back(tok_t'{6, 3'd2, 32'h65646362, 6'd6, 16'd3});
    tbl.push_back(tok_t'{6, 3'd4, 32'h0, 6'd0, 16'd3});

    repeat (2) @(posedge CCLK);
    @(negedge CCLK);
    check("rst_o_valid", 32'(O_VALID), 32'd0);
    check("rst_o_type", 32'(O_TYPE), 32'd0);
    check("rst_o_value", O_VALUE, 32'd0);
    check("rst_o_len", 32'(O_LEN), 32'd0);
    check("rst_o_line", 32'(O_LINE), 32'd0);
    @(posedge CCLK); #1;
    CRST = 1'b0;

    for (int c = 0; c <= 6; c++) begin
      do_reset();
      run_case(c, c == 3);
    end

    // Backpressure: NUM 12 must hold while the parser stalls.
    do_reset();
    push(3'd1, 32'd12, 6'd0, 16'd1);
    push(3'd3, 32'h2B, 6'd0, 16'd1);
    push(3'd1, 32'd3, 6'd0, 16'd1);
    push(3'd4, 32'h0, 6'd0, 16'd1);
    O_READY = 1'b0;
    fork
      feed("12 + 3", 1'b0);
      begin
        w = 0;
        while (!O_VALID && w < 100) begin
          @(posedge CCLK); #1;
          w++;
        end
        check("bp_o_valid", 32'(O_VALID), 32'd1);
        for (int k = 0; k < 10; k++) begin
          @(negedge CCLK);
          check("bp_hold_value", O_VALUE, 32'd12);
          check("bp_hold_type", 32'(O_TYPE), 32'd1);
          @(posedge CCLK); #1;
        end
        @(negedge CCLK);
        check("bp_stall_i_ready", 32'(I_READY), 32'd0);
        @(posedge CCLK); #1;
        O_READY = 1'b1;
      end
    join
    check_done();

    // Reset in the middle of an identifier on line 2.
    do_reset();
    drive_char(8'h0A);
    drive_char(8'h61);
    drive_char(8'h62);
    drive_char(8'h63);
    I_VALID = 1'b1;
    I_CHAR  = 8'h64;
    CRST    = 1'b1;
    @(posedge CCLK); #1;
    CRST    = 1'b0;
    I_VALID = 1'b0;
    I_CHAR  = 8'h20;
    @(negedge CCLK);
    check("midrst_o_valid", 32'(O_VALID), 32'd0);
    check("midrst_skip_ready", 32'(I_READY), 32'd1);
    @(posedge CCLK); #1;
    push(3'd1, 32'd9, 6'd0, 16'd1);
    push(3'd4, 32'h0, 6'd0, 16'd1);
    feed("9", 1'b0);
    check_done();

    // Single-char punctuator: O_VALID two cycles after acceptance.
    do_reset();
    push(3'd3, 32'h3B, 6'd0, 16'd1);
    I_VALID = 1'b1;
    I_CHAR  = 8'h3B;
    @(negedge CCLK);
    check("lat_i_ready", 32'(I_READY), 32'd1);
    @(posedge CCLK); #1;
    I_VALID = 1'b0;
    @(negedge CCLK);
    check("lat_cycle1", 32'(O_VALID), 32'd0);
    @(posedge CCLK); #1;
    @(negedge CCLK);
    check("lat_cycle2", 32'(O_VALID), 32'd1);
    @(posedge CCLK); #1;
    check("lat_popped", 32'(sb.size()), 32'd0);
    sb.delete();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
